// File: rtl/peripheral_spram_pkg.sv
// Shared types and limits for the SPRAM bank and its storage array.
package peripheral_spram_pkg;

  // Bank sequencing: zero-fill after reset, then serve requests.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } spram_state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  // Number of byte lanes in a data word.
  function automatic int byte_lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/peripheral_spram_array.sv
// Raw byte-enabled word storage: one write port, one registered read port.
// Holds no reset so it can map onto block RAM.
module peripheral_spram_array
  import peripheral_spram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_WORDS  = 256,
  parameter int IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1,
  parameter int LANES      = byte_lanes(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [LANES-1:0]      wr_be_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Byte-lane write: only enabled lanes are updated.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int k = 0; k < LANES; k++) begin
        if (wr_be_i[k]) begin
          mem[wr_idx_i][8*k +: 8] <= wr_data_i[8*k +: 8];
        end
      end
    end
  end

  // Registered read; sees writes committed on earlier edges.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_o <= mem[rd_idx_i];
    end
  end

endmodule

// File: rtl/peripheral_spram_bank.sv
// Byte-addressed SPRAM bank behind the AXI4 SPRAM bridge: post-reset
// zero-fill, range check and a READ_LATENCY-deep response pipeline.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_INIT | zero-fill one word per cycle, requests not accepted
//   ST_IDLE | ready_o=1, one request per cycle, stays until reset
module peripheral_spram_bank
  import peripheral_spram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_WORDS    = 256,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ENABLE  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    ready_o,
  output logic                    rsp_valid_o,
  output logic                    rsp_err_o,
  output logic [DATA_WIDTH-1:0]   data_o
);

  localparam int LANES = byte_lanes(DATA_WIDTH);
  localparam int OFF_W = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_WORDS_A = ADDR_WIDTH'(MEM_WORDS);
  localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(MEM_WORDS - 1);

  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
    $fatal(1, "peripheral_spram_bank: READ_LATENCY %0d outside supported range", READ_LATENCY);
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $fatal(1, "peripheral_spram_bank: DATA_WIDTH %0d is not a whole number of bytes", DATA_WIDTH);
  end

  spram_state_t          state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  init_we;
  logic                  accept;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx_full;

  logic                  arr_we;
  logic [IDX_W-1:0]      arr_widx;
  logic [LANES-1:0]      arr_be;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  arr_re;
  logic [DATA_WIDTH-1:0] arr_rdata;

  logic                  s1_valid, s1_err, s1_read;
  logic [DATA_WIDTH-1:0] s1_data;

  assign idx_full = addr_i >> OFF_W;
  assign in_range = (idx_full < MEM_WORDS_A);
  assign ready_o  = (state_q == ST_IDLE);
  // Gated by reset so nothing reaches the array while reset is held.
  assign accept   = req_i & ready_o & ~rst_i;

  // State and fill-counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= (INIT_ENABLE != 0) ? ST_INIT : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: walk the counter over every word, then open for traffic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = ~rst_i;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Array port mux: fill writes own the port during init.
  always_comb begin
    arr_we    = 1'b0;
    arr_widx  = idx_full[IDX_W-1:0];
    arr_be    = be_i;
    arr_wdata = data_i;
    if (init_we) begin
      arr_we    = 1'b1;
      arr_widx  = cnt_q;
      arr_be    = {LANES{1'b1}};
      arr_wdata = '0;
    end else begin
      arr_we = accept & we_i & in_range;
    end
  end

  assign arr_re = accept & ~we_i & in_range;

  peripheral_spram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .IDX_W      (IDX_W),
    .LANES      (LANES)
  ) u_array (
    .clk_i     (clk_i),
    .wr_en_i   (arr_we),
    .wr_idx_i  (arr_widx),
    .wr_be_i   (arr_be),
    .wr_data_i (arr_wdata),
    .rd_en_i   (arr_re),
    .rd_idx_i  (idx_full[IDX_W-1:0]),
    .rd_data_o (arr_rdata)
  );

  // First response stage, aligned with the array's registered read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_read  <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_err   <= accept & ~in_range;
      s1_read  <= arr_re;
    end
  end

  // Array output is unreset and holds stale words; only a live read passes it.
  assign s1_data = s1_read ? arr_rdata : '0;

  if (READ_LATENCY == 1) begin : g_direct
    assign rsp_valid_o = s1_valid;
    assign rsp_err_o   = s1_err;
    assign data_o      = s1_data;
  end else begin : g_pipe
    logic [READ_LATENCY-2:0] v_sr;
    logic [READ_LATENCY-2:0] e_sr;
    logic [DATA_WIDTH-1:0]   d_sr [READ_LATENCY-1];

    // Extra response stages; reset flushes them so no stale pulse escapes.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v_sr <= '0;
        e_sr <= '0;
        for (int i = 0; i < READ_LATENCY - 1; i++) d_sr[i] <= '0;
      end else begin
        v_sr[0] <= s1_valid;
        e_sr[0] <= s1_err;
        d_sr[0] <= s1_data;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          v_sr[i] <= v_sr[i-1];
          e_sr[i] <= e_sr[i-1];
          d_sr[i] <= d_sr[i-1];
        end
      end
    end

    assign rsp_valid_o = v_sr[READ_LATENCY-2];
    assign rsp_err_o   = e_sr[READ_LATENCY-2];
    assign data_o      = d_sr[READ_LATENCY-2];
  end

endmodule

// File: tb/tb_peripheral_spram_bank.sv
// Directed bench for peripheral_spram_bank (READ_LATENCY=3, 256 x 16-bit).
// Expected responses are queued when a request is driven and retired by a
// negedge monitor that also checks the arrival cycle.
module tb_peripheral_spram_bank;

  localparam int RL = 3;
  localparam int MW = 256;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i  = 1'b0;
  logic [31:0] addr_i = '0;
  logic [1:0]  be_i = '0;
  logic [15:0] data_i = '0;
  logic        ready_o;
  logic        rsp_valid_o;
  logic        rsp_err_o;
  logic [15:0] data_o;

  peripheral_spram_bank #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (16),
    .MEM_WORDS    (MW),
    .READ_LATENCY (RL),
    .INIT_ENABLE  (1)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .be_i        (be_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_err_o   (rsp_err_o),
    .data_o      (data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [15:0] model [MW];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (rsp_valid_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("rsp_without_request", rsp_valid_o, 1'b0);
        end else begin
          mon_e = sb_q.pop_front();
          check("rsp_cycle", cyc, mon_e.cyc);
          check("rsp_err", rsp_err_o, mon_e.err);
          check("rsp_data", data_o, mon_e.data);
        end
      end else begin
        check("idle_valid", rsp_valid_o, 1'b0);
        check("idle_err", rsp_err_o, 1'b0);
        check("idle_data", data_o, 16'h0);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] be,
                       input logic [15:0] data);
    logic [31:0] idx;
    logic        err;
    exp_t        e;
    idx = addr >> 1;
    err = (idx >= MW);
    e.cyc = cyc + RL;
    e.err = err;
    e.data = 16'h0;
    if (we) begin
      if (!err) begin
        if (be[0]) model[idx[7:0]][7:0]  = data[7:0];
        if (be[1]) model[idx[7:0]][15:8] = data[15:8];
      end
    end else if (!err) begin
      e.data = model[idx[7:0]];
    end
    sb_q.push_back(e);
    req_i = 1'b1;
    we_i = we;
    addr_i = addr;
    be_i = be;
    data_i = data;
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    req_i = 1'b0;
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic zero_model();
    for (int i = 0; i < MW; i++) model[i] = 16'h0;
  endtask

  // Counts ready_o low for exactly MW samples after release, then high.
  task automatic release_and_wait_init();
    int low_cnt;
    low_cnt = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < MW; i++) begin
      @(negedge clk_i);
      if (ready_o === 1'b0) low_cnt++;
    end
    check("init_low_cycles", low_cnt, MW);
    @(negedge clk_i);
    check("init_ready_high", ready_o, 1'b1);
    zero_model();
    @(posedge clk_i); #1;
  endtask

  initial begin
    int unsigned r;
    zero_model();

    // Reset values.
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    mon_en = 1'b1;
    @(negedge clk_i);
    check("rst_ready", ready_o, 1'b0);
    check("rst_valid", rsp_valid_o, 1'b0);
    check("rst_err", rsp_err_o, 1'b0);
    check("rst_data", data_o, 16'h0);

    // Requests during init are ignored; reset at init cycle 100 restarts the fill.
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req_i = 1'b1;
    we_i = 1'b1;
    addr_i = 32'h20;
    be_i = 2'b11;
    data_i = 16'hDEAD;
    repeat (100) begin
      @(negedge clk_i);
      check("init_gated_ready", ready_o, 1'b0);
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    release_and_wait_init();

    // Every word reads back as zero after the fill.
    for (int i = 0; i < MW; i++) issue(1'b0, 32'(i * 2), 2'b00, 16'h0);
    idle(1);

    // Byte enables, and read right after write to the same word.
    issue(1'b1, 32'h10, 2'b11, 16'hBEEF);
    issue(1'b1, 32'h10, 2'b01, 16'h12AA);
    issue(1'b0, 32'h10, 2'b00, 16'h0);
    issue(1'b0, 32'h11, 2'b00, 16'h0);
    issue(1'b1, 32'h10, 2'b10, 16'h77CC);
    issue(1'b1, 32'h10, 2'b00, 16'hFFFF);
    issue(1'b0, 32'h10, 2'b00, 16'h0);
    idle(2);

    // Back-to-back reads, four consecutive responses.
    issue(1'b1, 32'h0, 2'b11, 16'h0001);
    issue(1'b1, 32'h2, 2'b11, 16'h0002);
    issue(1'b1, 32'h4, 2'b11, 16'h0003);
    issue(1'b1, 32'h6, 2'b11, 16'h0004);
    idle(1);
    issue(1'b0, 32'h0, 2'b00, 16'h0);
    issue(1'b0, 32'h2, 2'b00, 16'h0);
    issue(1'b0, 32'h4, 2'b00, 16'h0);
    issue(1'b0, 32'h7, 2'b00, 16'h0);
    idle(3);

    // Out-of-range accesses flag an error and leave memory alone.
    issue(1'b1, 32'h200, 2'b11, 16'h5555);
    issue(1'b0, 32'h200, 2'b00, 16'h0);
    issue(1'b0, 32'h0, 2'b00, 16'h0);
    issue(1'b1, 32'hFFFF_FFFE, 2'b11, 16'h5555);
    issue(1'b0, 32'h1FF, 2'b00, 16'h0);
    issue(1'b0, 32'h1FE, 2'b00, 16'h0);
    idle(2);

    // Mixed random traffic with idle gaps.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) idle(1);
      else issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 16'h21F)),
                 2'($urandom_range(0, 3)), 16'($urandom));
    end
    idle(RL + 2);

    // Reset while two reads are in flight: nothing may come out.
    issue(1'b1, 32'h30, 2'b11, 16'hA5A5);
    idle(RL + 1);
    issue(1'b0, 32'h30, 2'b00, 16'h0);
    issue(1'b0, 32'h30, 2'b00, 16'h0);
    req_i = 1'b0;
    rst_i = 1'b1;
    sb_q.delete();
    @(posedge clk_i); #1;
    release_and_wait_init();

    // The fill cleared what was written before the reset.
    issue(1'b0, 32'h30, 2'b00, 16'h0);
    issue(1'b0, 32'h10, 2'b00, 16'h0);
    issue(1'b1, 32'h30, 2'b01, 16'h00C3);
    issue(1'b0, 32'h30, 2'b00, 16'h0);
    idle(1);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    check("drain_pending", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/peripheral_spram_bank.md
# peripheral_spram_bank

Byte-addressed, byte-enabled single-port RAM bank that consumes the simple memory request interface (req/we/addr/be/data) produced by the AXI4 SPRAM bridge and returns read data to it. It adds a configurable read pipeline, an optional post-reset zero-fill sequence gating acceptance, and out-of-range address detection. It sits directly downstream of `peripheral_axi4_spram` in the SPRAM peripheral.

## Interface
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 16: data width in bits; multiple of 8.
- MEM_WORDS, 256: number of DATA_WIDTH words stored.
- READ_LATENCY, 1: request-to-response cycles; legal range 1..4.
- INIT_ENABLE, 1: 1 = zero-fill all words after reset.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  1  request strobe.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  byte address.
- be_i  in  DATA_WIDTH/8  byte enables (writes only).
- data_i  in  DATA_WIDTH  write data.
- ready_o  out  1  bank accepts requests.
- rsp_valid_o  out  1  one-cycle response pulse per accepted request.
- rsp_err_o  out  1  response is for an out-of-range address.
- data_o  out  DATA_WIDTH  read data, valid with rsp_valid_o.

## Operation
- Accept = req_i & ready_o. When ready_o is low, requests are ignored and produce no response.
- Word index = addr_i >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored.
- Out of range: index >= MEM_WORDS. Writes are suppressed. Reads return 0. The response carries rsp_err_o=1.
- Write: for each k with be_i[k]=1, word[index][8k+7:8k] <= data_i[8k+7:8k]. Other bytes are unchanged. be_i=0 is a legal no-op write.
- Every accepted request, read or write, yields exactly one response. For writes, data_o=0.
- States: INIT, IDLE.
  - Reset → INIT if INIT_ENABLE, else IDLE.
  - INIT: a counter steps 0..MEM_WORDS-1 and writes 0 to one word per cycle, all bytes. After the last word the state moves to IDLE.
  - IDLE: ready_o=1. This state persists until reset.
- Reset mid-INIT restarts the fill from word 0.
- Reset mid-operation: all response pipeline stages are cleared, so no stale rsp_valid_o. Memory contents are untouched by reset; only INIT clears them.
- Single port, one request per cycle, so no read/write collision exists. A read issued the cycle after a write to the same word returns the new data.

## Timing
- Reset values: ready_o=0 (INIT) or 1 (INIT_ENABLE=0, from the first cycle after reset); rsp_valid_o=0; rsp_err_o=0; data_o=0.
- Init duration: exactly MEM_WORDS cycles. ready_o rises on the MEM_WORDS-th rising edge after the edge that samples rst_i low.
- Latency: request accepted at edge N → rsp_valid_o/rsp_err_o/data_o valid during the cycle after edge N+READ_LATENCY-1, i.e. registered, READ_LATENCY pipeline stages.
- Throughput: fully pipelined, one request per cycle, no backpressure once in IDLE.
- Between responses, data_o holds 0; it is not held from the previous read.
- Write takes effect at the accepting edge.

## Structure
- `peripheral_spram_pkg` holds:
  - the state enum typedef (INIT, IDLE);
  - READ_LATENCY_MIN=1 and READ_LATENCY_MAX=4;
  - a byte-lane count helper function.
- Sub-module `peripheral_spram_array` is the raw byte-enabled storage: one write port with byte enables, one read port with a registered output, no reset. The bank supplies the FSM, init counter, range check, and response pipeline of READ_LATENCY-1 extra stages.
- Elaboration check: fatal if READ_LATENCY is out of range or DATA_WIDTH%8≠0.

## Test plan
- Init (MEM_WORDS=256, INIT_ENABLE=1): release reset → ready_o low for 256 cycles, then high. Read every word → 0x0000, rsp_err_o=0.
- Byte enables (DATA_WIDTH=16): write 0xBEEF be=11 to addr 0x10, then 0x12AA be=01 to 0x10, read 0x10 → 0xBEAA.
- Latency/throughput (READ_LATENCY=3): back-to-back reads of addresses 0,2,4,6 holding 1,2,3,4 → rsp_valid_o high 4 consecutive cycles, starting 3 edges after the first request, with data 1,2,3,4.
- Out of range: write 0x5555 to byte addr 0x200 (index 256) → response rsp_err_o=1. Then read 0x200 → data_o=0, rsp_err_o=1. Word 0 is unchanged.
- Gating: assert req_i during INIT → no response. Assert rst_i at init cycle 100 → ready_o stays low a full 256 cycles after release.
- Reset mid-pipeline (READ_LATENCY=4): issue 2 reads, assert rst_i the next cycle → no rsp_valid_o pulse follows.
